// File: rtl/prog_loader.sv
// prog_loader
// Receives a framed program over a byte stream and writes it into the CPU
// instruction memory. Every address beyond the loaded program is written with
// FILL_WORD. The CPU is held in reset while the load is in progress and is only
// released once a frame with a correct checksum has been written in full.
//
// Frame: SYNC_BYTE, N[15:8], N[7:0], N words (high byte first), CSUM
//        CSUM = modulo-256 sum of the 2N data bytes.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   in_data/valid/ready  byte stream in (transfer = in_valid & in_ready)
//   wr_en/addr/data   instruction-memory write port
//   cpu_rst           holds the CPU in reset (active-high)
//   done / err        result of the last load (sticky until next SYNC_BYTE)
module prog_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] FILL_WORD = 16'h0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [16:0]     DEPTH_17 = 17'(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [3:0] {
        IDLE, CNT_HI, CNT_LO, D_HI, D_LO, CSUM, FILL, DONE, ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [7:0]        cnt_hi_reg;
    logic [7:0]        hi_reg;
    logic [7:0]        sum_reg;
    // One bit wider than the address so N == DEPTH is representable and the
    // index can step past the last address without wrapping.
    logic [ADDR_W:0]   n_reg;
    logic [ADDR_W:0]   idx_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [15:0]       wr_data_reg;
    logic              cpu_rst_reg;
    logic              done_reg;
    logic              err_reg;

    logic              accept;
    logic              is_sync;
    logic [15:0]       cnt_full;
    logic              cnt_oversize;
    logic              csum_ok;
    logic              last_word;

    // No bytes are taken while the fill sweep owns the write port.
    assign in_ready     = !RST && (state_reg != FILL);
    assign accept       = in_valid && in_ready;
    assign is_sync      = (in_data == SYNC_BYTE);
    assign cnt_full     = {cnt_hi_reg, in_data};
    assign cnt_oversize = ({1'b0, cnt_full} > DEPTH_17);
    assign csum_ok      = (in_data == sum_reg);
    assign last_word    = ((idx_reg + 1'b1) == n_reg);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: if (accept && is_sync) state_next = CNT_HI;
            CNT_HI:          if (accept) state_next = CNT_LO;
            CNT_LO: begin
                if (accept) begin
                    if (cnt_oversize)        state_next = ERR;
                    else if (cnt_full == '0) state_next = CSUM;
                    else                     state_next = D_HI;
                end
            end
            D_HI:            if (accept) state_next = D_LO;
            D_LO:            if (accept) state_next = last_word ? CSUM : D_HI;
            CSUM: begin
                if (accept) begin
                    if (!csum_ok)        state_next = ERR;
                    else if (n_reg[ADDR_W]) state_next = DONE;  // N == DEPTH: nothing to fill
                    else                 state_next = FILL;
                end
            end
            FILL:            if (idx_reg == LAST_IDX) state_next = DONE;
            default:         state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_hi_reg  <= '0;
            hi_reg      <= '0;
            sum_reg     <= '0;
            n_reg       <= '0;
            idx_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            cpu_rst_reg <= 1'b1;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE, ERR: begin
                    // Release the CPU one cycle after a successful load lands.
                    if (state_reg == DONE) cpu_rst_reg <= 1'b0;
                    if (accept && is_sync) begin
                        cpu_rst_reg <= 1'b1;
                        done_reg    <= 1'b0;
                        err_reg     <= 1'b0;
                        sum_reg     <= '0;
                        idx_reg     <= '0;
                    end
                end
                CNT_HI: if (accept) cnt_hi_reg <= in_data;
                CNT_LO: begin
                    if (accept) begin
                        n_reg <= cnt_full[ADDR_W:0];
                        if (cnt_oversize) err_reg <= 1'b1;
                    end
                end
                D_HI: begin
                    if (accept) begin
                        hi_reg  <= in_data;
                        sum_reg <= sum_reg + in_data;
                    end
                end
                D_LO: begin
                    if (accept) begin
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= idx_reg[ADDR_W-1:0];
                        wr_data_reg <= {hi_reg, in_data};
                        idx_reg     <= idx_reg + 1'b1;
                        sum_reg     <= sum_reg + in_data;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (!csum_ok)           err_reg  <= 1'b1;
                        else if (n_reg[ADDR_W]) done_reg <= 1'b1;
                    end
                end
                FILL: begin
                    // idx_reg already equals N when the sweep starts.
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= idx_reg[ADDR_W-1:0];
                    wr_data_reg <= FILL_WORD;
                    idx_reg     <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign cpu_rst = cpu_rst_reg;
    assign done    = done_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int          ADDR_W = 3;
    localparam logic [15:0] FILL_W = 16'hF00F;

    typedef logic [7:0] bq_t[$];

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_rst;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];   // {addr, data} of each expected write, in order

    prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .FILL_WORD(FILL_W)) dut (
        .CLK(CLK), .RST(RST),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write the DUT presents is matched in order.
    always @(negedge CLK) begin
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", wr_addr, wr_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({16'(wr_addr), wr_data} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                             wr_addr, wr_data, e[31:16], e[15:0]);
                end else begin
                    $display("write addr=%0d data=%h", wr_addr, wr_data);
                end
            end
        end
    end

    task automatic push_wr(input int a, input logic [15:0] d);
        exp_q.push_back({16'(a), d});
    endtask

    task automatic push_fill(input int from);
        for (int a = from; a < 2 ** ADDR_W; a++) push_wr(a, FILL_W);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge CLK);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=%b expected 1", in_ready);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input bq_t s, input int maxgap);
        foreach (s[i]) begin
            if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge CLK);
            send_byte(s[i]);
        end
        $display("frame sent: %0d bytes", s.size());
    endtask

    task automatic wait_status(input string name, input logic exp_done, input logic exp_err);
        int t = 0;
        while (done !== 1'b1 && err !== 1'b1 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done/err expected done=%b err=%b", name, exp_done, exp_err);
        end
        repeat (2) @(negedge CLK);
        chk({name, "_done"}, 32'(done), 32'(exp_done));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({name, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({name, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({name, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        bq_t f;

        repeat (3) @(negedge CLK);
        chk_reset_vals("reset");
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // One word, fill 1..7
        push_wr(0, 16'hFFFF); push_fill(1);
        f = '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFE};
        send_seq(f, 0);
        wait_status("one_word", 1'b1, 1'b0);

        // Two words, fill 2..7
        push_wr(0, 16'h1234); push_wr(1, 16'h6001); push_fill(2);
        f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h60, 8'h01, 8'hA7};
        send_seq(f, 0);
        wait_status("two_words", 1'b1, 1'b0);

        // Bad checksum: one write, no fill
        push_wr(0, 16'h0005);
        f = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h05, 8'h06};
        send_seq(f, 0);
        wait_status("bad_csum", 1'b0, 1'b1);

        // Oversize count: error right after count, no writes
        f = '{8'hA5, 8'h00, 8'h09};
        send_seq(f, 0);
        wait_status("oversize", 1'b0, 1'b1);

        // Exact fit: N=8, words {10+i,80+i}, sum mod 256 = B8
        f = '{8'hA5, 8'h00, 8'h08};
        for (int i = 0; i < 8; i++) begin
            push_wr(i, {8'(8'h10 + i), 8'(8'h80 + i)});
            f.push_back(8'(8'h10 + i));
            f.push_back(8'(8'h80 + i));
        end
        f.push_back(8'hB8);
        send_seq(f, 0);
        wait_status("exact_fit", 1'b1, 1'b0);

        // Zero length: fill 0..7
        push_fill(0);
        f = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(f, 0);
        wait_status("zero_len", 1'b1, 1'b0);

        // Two-word frame with random gaps between bytes
        push_wr(0, 16'h1234); push_wr(1, 16'h6001); push_fill(2);
        f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h60, 8'h01, 8'hA7};
        send_seq(f, 4);
        wait_status("gaps", 1'b1, 1'b0);

        // Reset pulsed after the 2nd data byte
        push_wr(0, 16'h1234);
        f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        send_seq(f, 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk_reset_vals("mid_reset");
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_reset_ready", 32'(in_ready), 32'd1);
        chk("mid_reset_pending", 32'(exp_q.size()), 32'd0);

        // Good frame after the reset
        push_wr(0, 16'hFFFF); push_fill(1);
        f = '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFE};
        send_seq(f, 0);
        wait_status("after_reset", 1'b1, 1'b0);

        // New SYNC after DONE re-asserts cpu_rst and clears done at once
        send_byte(8'hA5);
        chk("resync_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("resync_done", 32'(done), 32'd0);
        push_fill(0);
        f = '{8'h00, 8'h00, 8'h00};
        send_seq(f, 0);
        wait_status("resync", 1'b1, 1'b0);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
